// File: rtl/riscv_trace_pkg.sv
// rtl/riscv_trace_pkg.sv - shared state encoding and entry layout for the trace buffer
package riscv_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trace_state_e;

  // Flag nibble sits above {next_pc, pc}; these are bit positions inside it.
  localparam int FLAG_BRANCH = 0;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_SEL2   = 2;
  localparam int FLAG_DISC   = 3;

  function automatic int entry_w(input int xlen);
    return 2 * xlen + 4;
  endfunction

endpackage

// File: rtl/trace_ring_mem.sv
// rtl/trace_ring_mem.sv - circular entry storage, synchronous write, asynchronous read
module trace_ring_mem #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 68,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [AW-1:0]      i_wr_ptr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_rd_ptr,
  output logic [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_rd_ptr];

endmodule

// File: rtl/riscv_trace_buffer.sv
// rtl/riscv_trace_buffer.sv - triggerable execution-trace ring buffer with oldest-first drain
// Optional branch/discontinuity sample filter: TRACE_BRANCH_FILTER_EN
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int AW       = $clog2(DEPTH),
  localparam int EW       = entry_w(XLEN)
) (
`ifdef TRACE_BRANCH_FILTER_EN
  input  logic            filter_branch,
`endif
  input  logic            clk,
  input  logic            reset,
  input  logic            trace_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] next_pc,
  input  logic            branch,
  input  logic            zero,
  input  logic            sel2,
  input  logic            arm,
  input  logic            trig_en,
  input  logic [XLEN-1:0] trig_pc,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [EW-1:0]   rd_data,
  output logic [1:0]      state_o,
  output logic [AW:0]     count_o,
  output logic            ovf_o
);

  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

  trace_state_e    r_state, w_state_nxt;
  logic [AW-1:0]   r_wr_ptr, r_post, w_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_ovf;
  logic [XLEN-1:0] w_pc_inc;
  logic [3:0]      w_flags;
  logic [EW-1:0]   w_wdata, w_rdata;
  logic            w_disc, w_filter_ok, w_accept, w_we, w_trig, w_pop, w_rd_valid;

  assign w_pc_inc = pc + XLEN'(4);
  assign w_disc   = (next_pc != w_pc_inc);

`ifdef TRACE_BRANCH_FILTER_EN
  assign w_filter_ok = !filter_branch || branch || w_disc;
`else
  assign w_filter_ok = 1'b1;
`endif

  assign w_accept   = trace_valid && w_filter_ok && (r_state == ST_RUN || r_state == ST_POST);
  assign w_we       = w_accept && !arm;
  assign w_trig     = (r_state == ST_RUN) && trig_en && w_accept && (pc == trig_pc);
  assign w_rd_valid = (r_state == ST_FROZEN) && (r_count != '0);
  assign w_pop      = w_rd_valid && rd_ready;
  // Oldest entry is always count_o slots behind the write pointer.
  assign w_rd_ptr   = r_wr_ptr - r_count[AW-1:0];

  always_comb begin
    w_flags              = '0;
    w_flags[FLAG_BRANCH] = branch;
    w_flags[FLAG_ZERO]   = zero;
    w_flags[FLAG_SEL2]   = sel2;
    w_flags[FLAG_DISC]   = w_disc;
  end
  assign w_wdata = {w_flags, next_pc, pc};

  trace_ring_mem #(.DEPTH(DEPTH), .ENTRY_W(EW)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_wr_ptr(r_wr_ptr),
    .i_wdata (w_wdata),
    .i_rd_ptr(w_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (w_trig) w_state_nxt = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
        ST_POST: if (w_accept && r_post == AW'(1)) w_state_nxt = ST_FROZEN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    state_o  = r_state;
    rd_valid = w_rd_valid;
    rd_data  = w_rd_valid ? w_rdata : '0;
    count_o  = r_count;
    ovf_o    = r_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset || arm) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_post   <= '0;
    end else begin
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_count == FULL_CNT) r_ovf   <= 1'b1;
        else                     r_count <= r_count + (AW+1)'(1);
      end
      if (w_trig)                                  r_post <= POST_INIT;
      else if (r_state == ST_POST && w_accept)     r_post <= r_post - AW'(1);
      if (w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb/tb_riscv_trace_buffer.sv - randomized and directed bench with a queue-based reference model
module tb_riscv_trace_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int EW    = 2 * XLEN + 4;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 0, reset = 1, trace_valid = 0, branch = 0, zero = 0, sel2 = 0;
  logic arm = 0, trig_en = 0, rd_ready = 0;
  logic [XLEN-1:0] pc = 0, next_pc = 0, trig_pc = 0;
`ifdef TRACE_BRANCH_FILTER_EN
  logic filter_branch = 0;
`endif

  logic          rv_a, rv_b, ovf_a, ovf_b;
  logic [EW-1:0] rd_a, rd_b;
  logic [1:0]    st_a, st_b;
  logic [AW:0]   cnt_a, cnt_b;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(4)) dut (
`ifdef TRACE_BRANCH_FILTER_EN
    .filter_branch(filter_branch),
`endif
    .clk(clk), .reset(reset), .trace_valid(trace_valid), .pc(pc), .next_pc(next_pc),
    .branch(branch), .zero(zero), .sel2(sel2), .arm(arm), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_valid(rv_a), .rd_ready(rd_ready), .rd_data(rd_a),
    .state_o(st_a), .count_o(cnt_a), .ovf_o(ovf_a));

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
`ifdef TRACE_BRANCH_FILTER_EN
    .filter_branch(filter_branch),
`endif
    .clk(clk), .reset(reset), .trace_valid(trace_valid), .pc(pc), .next_pc(next_pc),
    .branch(branch), .zero(zero), .sel2(sel2), .arm(arm), .trig_en(trig_en),
    .trig_pc(trig_pc), .rd_valid(rv_b), .rd_ready(rd_ready), .rd_data(rd_b),
    .state_o(st_b), .count_o(cnt_b), .ovf_o(ovf_b));

  // Reference model: per instance, a queue of held entries (oldest at front).
  int            m_state [2];
  int            m_post  [2];
  bit            m_ovf   [2];
  logic [EW-1:0] m_q [2][$];
  int            post_trig [2] = '{4, 0};

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_post[k] = 0; m_ovf[k] = 0;
    end
  end

  task automatic model_step(input int k);
    logic disc, acc;
    disc = (next_pc != pc + 32'd4);
    acc  = trace_valid && (m_state[k] == 1 || m_state[k] == 2);
`ifdef TRACE_BRANCH_FILTER_EN
    acc  = acc && (!filter_branch || branch || disc);
`endif
    if (reset) begin
      m_state[k] = 0; m_post[k] = 0; m_ovf[k] = 0; m_q[k].delete();
    end else if (arm) begin
      m_state[k] = 1; m_ovf[k] = 0; m_q[k].delete();
    end else if (acc) begin
      m_q[k].push_back({disc, sel2, zero, branch, next_pc, pc});
      if (m_q[k].size() > DEPTH) begin
        void'(m_q[k].pop_front());
        m_ovf[k] = 1;
      end
      if (m_state[k] == 1) begin
        if (trig_en && pc == trig_pc) begin
          if (post_trig[k] == 0) m_state[k] = 3;
          else begin m_state[k] = 2; m_post[k] = post_trig[k]; end
        end
      end else begin
        m_post[k]--;
        if (m_post[k] == 0) m_state[k] = 3;
      end
    end else if (m_state[k] == 3 && m_q[k].size() > 0 && rd_ready) begin
      void'(m_q[k].pop_front());
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_one(input int k, input logic [1:0] st, input logic [AW:0] cnt,
                             input logic ovf, input logic rv, input logic [EW-1:0] rd);
    logic          e_rv;
    logic [EW-1:0] e_rd;
    e_rv = (m_state[k] == 3) && (m_q[k].size() > 0);
    e_rd = e_rv ? m_q[k][0] : '0;
    check_eq(k == 0 ? "state_a" : "state_b", st, m_state[k]);
    check_eq(k == 0 ? "count_a" : "count_b", cnt, m_q[k].size());
    check_eq(k == 0 ? "ovf_a" : "ovf_b", ovf, m_ovf[k]);
    check_eq(k == 0 ? "rdv_a" : "rdv_b", rv, e_rv);
    check_eq(k == 0 ? "rdd_a" : "rdd_b", rd, e_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_one(0, st_a, cnt_a, ovf_a, rv_a, rd_a);
    compare_one(1, st_b, cnt_b, ovf_b, rv_b, rd_b);
  endtask

  task automatic do_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic smp(input logic [31:0] p, input logic [31:0] np, input logic b);
    trace_valid = 1; pc = p; next_pc = np; branch = b; zero = 0; sel2 = 0;
    tick();
    trace_valid = 0;
  endtask

  task automatic fill_to_frozen();
    do_arm();
    trig_en = 1; trig_pc = 32'h40;
    for (int i = 0; i < 32; i++) smp(i * 4, i * 4 + 4, 0);
  endtask

  initial begin
    reset = 1; tick(); tick();
    check_eq("rst_state", st_a, 0);
    check_eq("rst_count", cnt_a, 0);
    check_eq("rst_rdv", rv_a, 0);
    check_eq("rst_rdd", rd_a, 0);
    reset = 0;

    do_arm();
    for (int i = 0; i < 6; i++) smp(i * 4, i * 4 + 4, 0);
    check_eq("run_state", st_a, 1);
    check_eq("run_count", cnt_a, 6);
    check_eq("run_ovf", ovf_a, 0);
    check_eq("run_rdv", rv_a, 0);

    fill_to_frozen();
    check_eq("frz_state", st_a, 3);
    check_eq("frz_count", cnt_a, 16);
    check_eq("frz_ovf", ovf_a, 1);
    rd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_rdv", rv_a, 1);
      check_eq("drain_pc", rd_a[31:0], 32'h14 + i * 4);
      tick();
    end
    check_eq("drain_end_rdv", rv_a, 0);
    check_eq("drain_end_state", st_a, 3);
    rd_ready = 0;

    do_arm();
    trig_en = 1; trig_pc = 0;
    smp(0, 4, 0);
    check_eq("pt0_state", st_b, 3);
    check_eq("pt0_count", cnt_b, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("pt0_hold_rdv", rv_b, 1);
      check_eq("pt0_hold_rdd", rd_b, 68'h0_00000004_00000000);
    end

    do_arm();
    trig_pc = 32'h20;
    smp(32'h20, 32'h08, 1);
    check_eq("br_disc", rd_b[67], 1);
    check_eq("br_branch", rd_b[64], 1);
    do_arm();
    trig_pc = 32'h24;
    smp(32'h24, 32'h28, 0);
    check_eq("seq_disc", rd_b[67], 0);

    trig_pc = 32'h30; trace_valid = 1; pc = 32'h30; next_pc = 32'h34;
    do_arm();
    trace_valid = 0;
    check_eq("armtrig_state", st_a, 1);
    check_eq("armtrig_count", cnt_a, 0);
    check_eq("armtrig_count_b", cnt_b, 0);

    fill_to_frozen();
    rd_ready = 1; tick(); tick(); tick();
    reset = 1; tick(); reset = 0; rd_ready = 0;
    check_eq("middrain_state", st_a, 0);
    check_eq("middrain_count", cnt_a, 0);
    check_eq("middrain_rdv", rv_a, 0);

`ifdef TRACE_BRANCH_FILTER_EN
    filter_branch = 1;
    do_arm();
    trig_en = 1; trig_pc = 32'h114;
    for (int i = 0; i < 10; i++) smp(32'h100 + i * 4, 32'h104 + i * 4, (i == 3 || i == 7));
    check_eq("filt_count", cnt_a, 2);
    check_eq("filt_notrig", st_b, 1);
    filter_branch = 0;
`endif

    trig_pc = $urandom_range(0, 15) * 4;
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      arm         = ($urandom_range(0, 39) == 0);
      trace_valid = ($urandom_range(0, 9) < 7);
      pc          = $urandom_range(0, 15) * 4;
      next_pc     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) * 4 : pc + 4;
      branch      = $urandom_range(0, 1);
      zero        = $urandom_range(0, 1);
      sel2        = $urandom_range(0, 1);
      rd_ready    = $urandom_range(0, 1);
      if (c % 50 == 0) trig_en = ($urandom_range(0, 3) != 0);
`ifdef TRACE_BRANCH_FILTER_EN
      filter_branch = ($urandom_range(0, 3) == 0);
`endif
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
